// File: rtl/alu_scheduler_pkg.sv
// Shared types and command encodings for the two-requester alu scheduler.
package alu_scheduler_pkg;

  localparam int NUM_REQ = 2;

  localparam logic [3:0] CMD_AND  = 4'd0;
  localparam logic [3:0] CMD_OR   = 4'd1;
  localparam logic [3:0] CMD_XOR  = 4'd2;
  localparam logic [3:0] CMD_NOT  = 4'd3;
  localparam logic [3:0] CMD_UADD = 4'd4;
  localparam logic [3:0] CMD_USUB = 4'd5;
  localparam logic [3:0] CMD_SADD = 4'd6;
  localparam logic [3:0] CMD_SSUB = 4'd7;
  localparam logic [3:0] CMD_UMUL = 4'd8;
  localparam logic [3:0] CMD_SMUL = 4'd9;
  localparam logic [3:0] CMD_LAST_LEGAL = CMD_SMUL;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    state_t state;
    logic   alu_en;
  } dbg_t;

endpackage

// File: rtl/alu_scheduler_if.sv
// Request/response bundle between the requesters (master) and the scheduler (slave).
interface alu_scheduler_if
  import alu_scheduler_pkg::*;
#(
  parameter int SIZE = 4
);

  // Handshake rule for both channels: a transfer happens on a rising edge where
  // valid and ready are both 1; the source holds valid and payload stable until then.
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [4*NUM_REQ-1:0]    req_command;
  logic [SIZE*NUM_REQ-1:0] req_a;
  logic [SIZE*NUM_REQ-1:0] req_b;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic                    rsp_id;
  logic [2*SIZE-1:0]       rsp_result;
  logic                    rsp_overflow;
  logic                    rsp_error;

  modport master (
    output req_valid, req_command, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_error
  );

  modport slave (
    input  req_valid, req_command, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_error
  );

endinterface

// File: rtl/alu_scheduler_alu.sv
// Combinational alu: logic, add/sub (SIZE-bit result, zero-extended) and full-width multiply.
module alu_scheduler_alu
  import alu_scheduler_pkg::*;
#(
  parameter int SIZE = 4
) (
  input  logic              enable,
  input  logic [3:0]        command,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic [2*SIZE-1:0] result,
  output logic              overflow
);

  logic [SIZE:0]            sum_u;
  logic [SIZE:0]            dif_u;
  logic [2*SIZE-1:0]        prod_u;
  logic [2*SIZE-1:0]        prod_s;
  logic signed [2*SIZE-1:0] a_s;
  logic signed [2*SIZE-1:0] b_s;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    sum_u    = {1'b0, a} + {1'b0, b};
    dif_u    = {1'b0, a} - {1'b0, b};
    prod_u   = {{SIZE{1'b0}}, a} * {{SIZE{1'b0}}, b};
    a_s      = {{SIZE{a[SIZE-1]}}, a};
    b_s      = {{SIZE{b[SIZE-1]}}, b};
    prod_s   = a_s * b_s;
    if (enable) begin
      case (command)
        CMD_AND:  result = {{SIZE{1'b0}}, a & b};
        CMD_OR:   result = {{SIZE{1'b0}}, a | b};
        CMD_XOR:  result = {{SIZE{1'b0}}, a ^ b};
        CMD_NOT:  result = {{SIZE{1'b0}}, ~a};
        CMD_UADD: begin
          result   = {{SIZE{1'b0}}, sum_u[SIZE-1:0]};
          overflow = sum_u[SIZE];
        end
        CMD_USUB: begin
          result   = {{SIZE{1'b0}}, dif_u[SIZE-1:0]};
          overflow = dif_u[SIZE];
        end
        // Signed overflow: operands agree in sign but the result does not.
        CMD_SADD: begin
          result   = {{SIZE{1'b0}}, sum_u[SIZE-1:0]};
          overflow = (a[SIZE-1] == b[SIZE-1]) && (sum_u[SIZE-1] != a[SIZE-1]);
        end
        CMD_SSUB: begin
          result   = {{SIZE{1'b0}}, dif_u[SIZE-1:0]};
          overflow = (a[SIZE-1] != b[SIZE-1]) && (dif_u[SIZE-1] != a[SIZE-1]);
        end
        CMD_UMUL: result = prod_u;
        CMD_SMUL: result = prod_s;
        default:  result = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one alu between two requesters; one operation in flight,
// operands held for EXEC_CYCLES before the registered response is presented.
module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter int SIZE        = 4,
  parameter int EXEC_CYCLES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_scheduler_if.slave       bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] op_count,
  output dbg_t                 dbg
);

  localparam int CW = $clog2(EXEC_CYCLES + 1);

  state_t            state;
  state_t            state_next;
  logic              rr_ptr;
  logic              grant;
  logic              accept;
  logic [3:0]        sel_cmd;
  logic [SIZE-1:0]   sel_a;
  logic [SIZE-1:0]   sel_b;
  logic              sel_illegal;
  logic [3:0]        cmd_q;
  logic [SIZE-1:0]   a_q;
  logic [SIZE-1:0]   b_q;
  logic              id_q;
  logic [CW-1:0]     exec_cnt;
  logic              alu_en;
  logic [2*SIZE-1:0] alu_result;
  logic              alu_overflow;
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [2*SIZE-1:0] rsp_result_q;
  logic              rsp_overflow_q;
  logic              rsp_error_q;

  // Grant the first valid requester at or after rr_ptr.
  always_comb begin
    grant         = rr_ptr ? bus.req_valid[1] : ~bus.req_valid[0];
    accept        = (state == IDLE) && (|bus.req_valid) && !reset;
    bus.req_ready = '0;
    if (accept) bus.req_ready[grant] = 1'b1;
    sel_cmd     = grant ? bus.req_command[7:4] : bus.req_command[3:0];
    sel_a       = grant ? bus.req_a[2*SIZE-1:SIZE] : bus.req_a[SIZE-1:0];
    sel_b       = grant ? bus.req_b[2*SIZE-1:SIZE] : bus.req_b[SIZE-1:0];
    sel_illegal = sel_cmd > CMD_LAST_LEGAL;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = sel_illegal ? RESP : EXEC;
      EXEC:    if (exec_cnt == '0) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr         <= 1'b0;
      cmd_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      id_q           <= 1'b0;
      exec_cnt       <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_error_q    <= 1'b0;
      op_count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cmd_q    <= sel_cmd;
            a_q      <= sel_a;
            b_q      <= sel_b;
            id_q     <= grant;
            rr_ptr   <= ~grant;
            exec_cnt <= CW'(EXEC_CYCLES - 1);
            // Illegal commands skip the alu and answer immediately.
            if (sel_illegal) begin
              rsp_valid_q    <= 1'b1;
              rsp_id_q       <= grant;
              rsp_result_q   <= '0;
              rsp_overflow_q <= 1'b0;
              rsp_error_q    <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (exec_cnt == '0) begin
            rsp_valid_q    <= 1'b1;
            rsp_id_q       <= id_q;
            rsp_result_q   <= alu_result;
            rsp_overflow_q <= alu_overflow;
            rsp_error_q    <= 1'b0;
          end else begin
            exec_cnt <= exec_cnt - CW'(1);
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            op_count    <= op_count + CNT_WIDTH'(1);
          end
        end
        default: rsp_valid_q <= 1'b0;
      endcase
    end
  end

  assign alu_en = (state == EXEC);

  alu_scheduler_alu #(.SIZE(SIZE)) u_alu (
    .enable   (alu_en),
    .command  (cmd_q),
    .a        (a_q),
    .b        (b_q),
    .result   (alu_result),
    .overflow (alu_overflow)
  );

  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_error    = rsp_error_q;
  assign busy             = (state != IDLE);
  assign dbg.state        = state;
  assign dbg.alu_en       = alu_en;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler: main instance (EXEC_CYCLES=2) plus a short-counter
// instance (EXEC_CYCLES=1, CNT_WIDTH=4) for the single-cycle and wrap cases.
module tb_alu_scheduler;
  import alu_scheduler_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   en_cycles = 0;
  logic [8:0] exp_q[$];

  alu_scheduler_if #(.SIZE(4)) bus0 ();
  alu_scheduler_if #(.SIZE(4)) bus1 ();
  logic        busy0, busy1;
  logic [15:0] op_count0;
  logic [3:0]  op_count1;
  dbg_t        dbg0, dbg1;

  alu_scheduler #(.SIZE(4), .EXEC_CYCLES(2), .CNT_WIDTH(16)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .busy(busy0), .op_count(op_count0), .dbg(dbg0));

  alu_scheduler #(.SIZE(4), .EXEC_CYCLES(1), .CNT_WIDTH(4)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .busy(busy1), .op_count(op_count1), .dbg(dbg1));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(negedge clk) if (dbg0.alu_en) en_cycles++;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    reset = 1'b1;
    bus0.req_valid = '0; bus0.req_command = '0; bus0.req_a = '0; bus0.req_b = '0; bus0.rsp_ready = 1'b0;
    bus1.req_valid = '0; bus1.req_command = '0; bus1.req_a = '0; bus1.req_b = '0; bus1.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input int inst, input int id, input logic [3:0] cmd,
                           input logic [3:0] a, input logic [3:0] b, output logic [1:0] rdy_first);
    int n;
    logic rdy;
    @(negedge clk);
    if (inst == 0) begin
      bus0.req_valid[id] = 1'b1;
      bus0.req_command[4*id +: 4] = cmd;
      bus0.req_a[4*id +: 4] = a;
      bus0.req_b[4*id +: 4] = b;
    end else begin
      bus1.req_valid[id] = 1'b1;
      bus1.req_command[4*id +: 4] = cmd;
      bus1.req_a[4*id +: 4] = a;
      bus1.req_b[4*id +: 4] = b;
    end
    #1;
    rdy_first = (inst == 0) ? bus0.req_ready : bus1.req_ready;
    rdy = (inst == 0) ? bus0.req_ready[id] : bus1.req_ready[id];
    n = 0;
    while (!rdy && n < 40) begin
      @(negedge clk); #1;
      n++;
      rdy = (inst == 0) ? bus0.req_ready[id] : bus1.req_ready[id];
    end
    if (!rdy) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout inst=%0d id=%0d got ready=0 want 1", inst, id);
    end
    @(posedge clk); #1;
    if (inst == 0) bus0.req_valid[id] = 1'b0;
    else           bus1.req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int inst, output int lat);
    logic v;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      v = (inst == 0) ? bus0.rsp_valid : bus1.rsp_valid;
    end while (!v && lat < 40);
    if (!v) begin
      vectors++; miscompares++;
      $display("FAIL rsp_timeout inst=%0d got rsp_valid=0 want 1", inst);
    end
  endtask

  task automatic handshake(input int inst);
    if (inst == 0) bus0.rsp_ready = 1'b1; else bus1.rsp_ready = 1'b1;
    @(posedge clk); #1;
    if (inst == 0) bus0.rsp_ready = 1'b0; else bus1.rsp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy0); end
    vectors++; if (bus0.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", bus0.rsp_valid); end
    vectors++; if (op_count0 !== 16'h0) begin miscompares++; $display("FAIL reset_op_count got %h want 0", op_count0); end
    vectors++; if (bus0.rsp_result !== 8'h00) begin miscompares++; $display("FAIL reset_rsp_result got %h want 00", bus0.rsp_result); end
    vectors++; if ({bus0.rsp_id, bus0.rsp_overflow, bus0.rsp_error} !== 3'b000) begin miscompares++; $display("FAIL reset_rsp_flags got %b want 000", {bus0.rsp_id, bus0.rsp_overflow, bus0.rsp_error}); end
    vectors++; if (bus0.req_ready !== 2'b00) begin miscompares++; $display("FAIL reset_req_ready got %b want 00", bus0.req_ready); end
    vectors++; if (dbg0.state !== IDLE) begin miscompares++; $display("FAIL reset_state got %0d want IDLE", dbg0.state); end
  endtask

  task automatic test_uadd();
    logic [1:0] rdy;
    int lat;
    apply_reset();
    drive_req(0, 0, CMD_UADD, 4'd9, 4'd8, rdy);
    vectors++; if (rdy !== 2'b01) begin miscompares++; $display("FAIL uadd_ready got %b want 01", rdy); end
    wait_rsp(0, lat);
    vectors++; if (lat != 3) begin miscompares++; $display("FAIL uadd_latency got %0d want 3", lat); end
    vectors++; if (bus0.rsp_result !== 8'h01) begin miscompares++; $display("FAIL uadd_result got %h want 01", bus0.rsp_result); end
    vectors++; if ({bus0.rsp_overflow, bus0.rsp_id, bus0.rsp_error} !== 3'b100) begin miscompares++; $display("FAIL uadd_flags got %b want 100", {bus0.rsp_overflow, bus0.rsp_id, bus0.rsp_error}); end
    vectors++; if (busy0 !== 1'b1) begin miscompares++; $display("FAIL uadd_busy got %b want 1", busy0); end
    handshake(0);
    @(negedge clk);
    vectors++; if (op_count0 !== 16'd1) begin miscompares++; $display("FAIL uadd_op_count got %0d want 1", op_count0); end
    vectors++; if ({bus0.rsp_valid, busy0} !== 2'b00) begin miscompares++; $display("FAIL uadd_idle got %b want 00", {bus0.rsp_valid, busy0}); end
  endtask

  task automatic test_round_robin();
    logic [8:0] exp;
    int n, got0, got1;
    apply_reset();
    for (int i = 0; i < 8; i++) exp_q.push_back({1'(i % 2), (i % 2 == 1) ? 8'h06 : 8'h08});
    @(negedge clk);
    bus0.req_command = {CMD_AND, CMD_AND};
    bus0.req_a = {4'h7, 4'hC};
    bus0.req_b = {4'hE, 4'hA};
    bus0.req_valid = 2'b11;
    bus0.rsp_ready = 1'b1;
    n = 0; got0 = 0; got1 = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (bus0.rsp_valid) begin
        exp = exp_q.pop_front();
        if (exp_q.size() == 0) bus0.req_valid = 2'b00;
        vectors++;
        if ({bus0.rsp_id, bus0.rsp_result} !== exp) begin
          miscompares++;
          $display("FAIL rr_rsp got id=%b result=%h want id=%b result=%h", bus0.rsp_id, bus0.rsp_result, exp[8], exp[7:0]);
        end
        if (bus0.rsp_id) got1++; else got0++;
      end
    end
    if (exp_q.size() > 0) begin
      vectors++; miscompares++;
      $display("FAIL rr_timeout got %0d responses missing want 0", exp_q.size());
      exp_q.delete();
    end
    bus0.req_valid = 2'b00;
    @(negedge clk);
    bus0.rsp_ready = 1'b0;
    vectors++; if (op_count0 !== 16'd8) begin miscompares++; $display("FAIL rr_op_count got %0d want 8", op_count0); end
    vectors++; if (got0 != 4 || got1 != 4) begin miscompares++; $display("FAIL rr_fairness got %0d/%0d want 4/4", got0, got1); end
  endtask

  task automatic test_hold_smul();
    logic [1:0] rdy;
    int lat;
    apply_reset();
    drive_req(0, 1, CMD_SMUL, 4'hF, 4'h3, rdy);
    bus0.req_command[3:0] = CMD_OR; bus0.req_a[3:0] = 4'h1; bus0.req_b[3:0] = 4'h2;
    bus0.req_valid[0] = 1'b1;
    wait_rsp(0, lat);
    vectors++; if (lat != 3) begin miscompares++; $display("FAIL smul_latency got %0d want 3", lat); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      vectors++;
      if ({bus0.rsp_valid, bus0.rsp_id, bus0.rsp_overflow, bus0.rsp_error, bus0.rsp_result} !== {4'b1100, 8'hFD}) begin
        miscompares++;
        $display("FAIL smul_hold cycle=%0d got v=%b id=%b ov=%b err=%b res=%h want 1 1 0 0 fd", k,
                 bus0.rsp_valid, bus0.rsp_id, bus0.rsp_overflow, bus0.rsp_error, bus0.rsp_result);
      end
      vectors++;
      if ({bus0.req_ready, busy0} !== 3'b001) begin
        miscompares++;
        $display("FAIL smul_blocked cycle=%0d got ready=%b busy=%b want 00 1", k, bus0.req_ready, busy0);
      end
    end
    bus0.req_valid[0] = 1'b0;
    handshake(0);
    @(negedge clk);
    vectors++; if (bus0.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL smul_release got %b want 0", bus0.rsp_valid); end
    vectors++; if (bus0.rsp_result !== 8'hFD) begin miscompares++; $display("FAIL smul_keep got %h want fd", bus0.rsp_result); end
    vectors++; if (op_count0 !== 16'd1) begin miscompares++; $display("FAIL smul_op_count got %0d want 1", op_count0); end
  endtask

  task automatic test_illegal();
    logic [1:0] rdy;
    int lat, en_before;
    apply_reset();
    en_before = en_cycles;
    drive_req(0, 0, 4'd12, 4'h5, 4'h3, rdy);
    wait_rsp(0, lat);
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL illegal_latency got %0d want 1", lat); end
    vectors++; if (bus0.rsp_result !== 8'h00) begin miscompares++; $display("FAIL illegal_result got %h want 00", bus0.rsp_result); end
    vectors++; if ({bus0.rsp_overflow, bus0.rsp_error, bus0.rsp_id} !== 3'b010) begin miscompares++; $display("FAIL illegal_flags got %b want 010", {bus0.rsp_overflow, bus0.rsp_error, bus0.rsp_id}); end
    handshake(0);
    @(negedge clk);
    vectors++; if (en_cycles != en_before) begin miscompares++; $display("FAIL illegal_alu_en got %0d cycles want 0", en_cycles - en_before); end
    vectors++; if (op_count0 !== 16'd1) begin miscompares++; $display("FAIL illegal_op_count got %0d want 1", op_count0); end
  endtask

  task automatic test_ops();
    logic [3:0] cmds[4] = '{CMD_USUB, CMD_SADD, CMD_UMUL, CMD_XOR};
    logic [3:0] as[4]   = '{4'h3, 4'h7, 4'hF, 4'h5};
    logic [3:0] bs[4]   = '{4'h5, 4'h1, 4'hF, 4'hF};
    logic [8:0] exps[4] = '{{1'b1, 8'h0E}, {1'b1, 8'h08}, {1'b0, 8'hE1}, {1'b0, 8'h0A}};
    logic [1:0] rdy;
    int lat;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_req(0, 0, cmds[i], as[i], bs[i], rdy);
      wait_rsp(0, lat);
      vectors++;
      if ({bus0.rsp_overflow, bus0.rsp_result} !== exps[i] || bus0.rsp_error !== 1'b0) begin
        miscompares++;
        $display("FAIL ops_cmd%0d got ov=%b res=%h err=%b want ov=%b res=%h err=0", cmds[i],
                 bus0.rsp_overflow, bus0.rsp_result, bus0.rsp_error, exps[i][8], exps[i][7:0]);
      end
      handshake(0);
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [1:0] rdy;
    int seen;
    apply_reset();
    drive_req(0, 0, CMD_UADD, 4'h3, 4'h4, rdy);
    @(negedge clk);
    vectors++; if (dbg0.state !== EXEC) begin miscompares++; $display("FAIL midreset_pre got state=%0d want EXEC", dbg0.state); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    vectors++; if ({busy0, bus0.rsp_valid} !== 2'b00) begin miscompares++; $display("FAIL midreset_idle got busy=%b v=%b want 0 0", busy0, bus0.rsp_valid); end
    vectors++; if (op_count0 !== 16'd0) begin miscompares++; $display("FAIL midreset_op_count got %0d want 0", op_count0); end
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus0.rsp_valid) seen++;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL midreset_no_rsp got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_wrap_exec1();
    logic [1:0] rdy;
    int lat;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      drive_req(1, 0, CMD_UADD, 4'(i), 4'd1, rdy);
      wait_rsp(1, lat);
      if (i == 0) begin
        vectors++; if (lat != 2) begin miscompares++; $display("FAIL exec1_latency got %0d want 2", lat); end
      end
      vectors++;
      if ({bus1.rsp_overflow, bus1.rsp_result} !== {(i == 15), 4'h0, 4'(i + 1)}) begin
        miscompares++;
        $display("FAIL exec1_result i=%0d got ov=%b res=%h want ov=%b res=%h", i,
                 bus1.rsp_overflow, bus1.rsp_result, (i == 15), 4'(i + 1));
      end
      if (i == 15) begin
        vectors++; if (op_count1 !== 4'hF) begin miscompares++; $display("FAIL exec1_pre_wrap got %h want f", op_count1); end
      end
      handshake(1);
    end
    @(negedge clk);
    vectors++; if (op_count1 !== 4'h0) begin miscompares++; $display("FAIL exec1_wrap got %h want 0", op_count1); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_uadd();
    test_round_robin();
    test_hold_smul();
    test_illegal();
    test_ops();
    test_reset_mid_exec();
    test_wrap_exec1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
